// File: rtl/divider_taint_track_word_if.sv
// Request/result bundle for the taint-tracked word divider.
// master: issues start + operands (with taints), observes results + done pulse.
// slave: the divider itself.
interface divider_taint_track_word_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             start_t;
   logic [WIDTH-1:0] dividend;
   logic             dividend_t;
   logic [WIDTH-1:0] divisor;
   logic             divisor_t;
   logic [WIDTH-1:0] quotient;
   logic             quotient_t;
   logic [WIDTH-1:0] remainder;
   logic             remainder_t;
   logic             quotientDone;
   logic             quotientDone_t;

   modport master (
      output start, start_t, dividend, dividend_t, divisor, divisor_t,
      input  quotient, quotient_t, remainder, remainder_t, quotientDone, quotientDone_t
   );

   modport slave (
      input  start, start_t, dividend, dividend_t, divisor, divisor_t,
      output quotient, quotient_t, remainder, remainder_t, quotientDone, quotientDone_t
   );
endinterface

// File: rtl/divider_taint_track_word.sv
// Constant-time restoring divider with word-level taint shadow bits.
// Latency: start sampled at edge k -> quotientDone pulses in the cycle after edge k+WIDTH+2.
// Backpressure: none; start is ignored while busy, results held until the next LOAD.
//
// Ports: clk (rising edge), rst (async, active-low), bus (slave modport):
//   start/start_t, dividend/dividend_t, divisor/divisor_t in;
//   quotient/quotient_t, remainder/remainder_t, quotientDone/quotientDone_t out.
// Option macro DIV_TAINT_KILL_EN: clears the control taint on DONE->IDLE;
// when undefined the control taint is sticky until reset.
module divider_taint_track_word #(
   parameter int WIDTH = 32
) (
   input logic                     clk,
   input logic                     rst,
   divider_taint_track_word_if.slave bus
);
   // Counter is wide enough to hold WIDTH, so the wrap after the last
   // iteration never aliases a live count.
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_e;

   state_e           state;
   logic             state_t;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   rem;
   logic             quo_t;
   logic             rem_t;
   logic             done;
   logic             done_t;

   // One extra bit beyond the WIDTH+1 partial remainder carries the borrow,
   // since the shifted remainder can reach 2*divisor-1.
   logic [WIDTH+1:0] rem_sh;
   logic [WIDTH+1:0] diff;
   logic             borrow;

   always_comb begin
      rem_sh = {rem, quo[WIDTH-1]};
      diff   = rem_sh - {2'b00, dvs};
      borrow = diff[WIDTH+1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         state_t <= 1'b0;
         cnt     <= '0;
         quo     <= '0;
         dvs     <= '0;
         rem     <= '0;
         quo_t   <= 1'b0;
         rem_t   <= 1'b0;
         done    <= 1'b0;
         done_t  <= 1'b0;
      end else begin
         done   <= 1'b0;
         // Done taint is the control taint, registered to line up with the
         // registered done pulse (so a kill on DONE->IDLE still taints it).
         done_t <= state_t;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state   <= LOAD;
                  // OR keeps a sticky taint sticky; with the kill enabled
                  // state_t is already 0 here.
                  state_t <= state_t | bus.start_t;
               end
            end
            LOAD: begin
               quo   <= bus.dividend;
               dvs   <= bus.divisor;
               rem   <= '0;
               cnt   <= '0;
               quo_t <= bus.dividend_t | bus.divisor_t | state_t;
               rem_t <= bus.dividend_t | bus.divisor_t | state_t;
               state <= ITER;
            end
            ITER: begin
               // Divide-by-zero falls out naturally: the trial never borrows.
               quo   <= {quo[WIDTH-2:0], ~borrow};
               rem   <= borrow ? rem_sh[WIDTH:0] : diff[WIDTH:0];
               quo_t <= quo_t | state_t;
               rem_t <= rem_t | state_t;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
`ifdef DIV_TAINT_KILL_EN
               // Safe to kill: every path has reconverged at IDLE after a
               // fixed number of cycles.
               state_t <= 1'b0;
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.quotient       = quo;
   assign bus.quotient_t     = quo_t;
   assign bus.remainder      = rem[WIDTH-1:0];
   assign bus.remainder_t    = rem_t;
   assign bus.quotientDone   = done;
   assign bus.quotientDone_t = done_t;
endmodule

// File: tb/tb_divider_taint_track_word.sv
module tb_divider_taint_track_word;
   localparam int WIDTH = 32;
`ifdef DIV_TAINT_KILL_EN
   localparam logic KILL = 1'b1;
`else
   localparam logic KILL = 1'b0;
`endif

   logic clk;
   logic rst;
   int   tests;
   int   fails;
   int   lat;
   int   pulses;

   divider_taint_track_word_if #(.WIDTH(WIDTH)) bus ();

   divider_taint_track_word #(.WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives operands and a one-edge start pulse; operands stay held.
   task automatic launch(input logic [31:0] dvd, input logic [31:0] dvs,
                         input logic dvd_t, input logic dvs_t, input logic st_t);
      bus.dividend   = dvd;
      bus.divisor    = dvs;
      bus.dividend_t = dvd_t;
      bus.divisor_t  = dvs_t;
      bus.start_t    = st_t;
      bus.start      = 1'b1;
      step();
      bus.start      = 1'b0;
      bus.start_t    = 1'b0;
   endtask

   // Edges counted from the launch edge until done is seen; 0 if never.
   task automatic wait_done(output int n_out);
      n_out = 0;
      for (int n = 1; n <= 40; n++) begin
         step();
         if (bus.quotientDone) begin
            n_out = n;
            break;
         end
      end
   endtask

   task automatic count_pulses(input int cycles, output int cnt_out);
      cnt_out = 0;
      for (int n = 0; n < cycles; n++) begin
         step();
         if (bus.quotientDone) cnt_out++;
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      bus.start      = 1'b0;
      bus.start_t    = 1'b0;
      bus.dividend   = '0;
      bus.divisor    = '0;
      bus.dividend_t = 1'b0;
      bus.divisor_t  = 1'b0;
      rst = 1'b1;
      #2 rst = 1'b0;
      step();
      step();
      check("rst_quotient",  bus.quotient, 32'h0);
      check("rst_remainder", bus.remainder, 32'h0);
      check("rst_done",      {31'b0, bus.quotientDone}, 32'h0);
      check("rst_taints",    {29'b0, bus.quotient_t, bus.remainder_t, bus.quotientDone_t}, 32'h0);
      rst = 1'b1;
      step();

      // Basic divide
      launch(32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
      wait_done(lat);
      check("basic_latency",   lat, 34);
      check("basic_quotient",  bus.quotient, 32'd14);
      check("basic_remainder", bus.remainder, 32'd2);
      check("basic_taints",    {29'b0, bus.quotient_t, bus.remainder_t, bus.quotientDone_t}, 32'h0);
      step();
      check("basic_done_one_cycle", {31'b0, bus.quotientDone}, 32'h0);

      // Divide by zero
      launch(32'h1234, 32'h0, 1'b0, 1'b0, 1'b0);
      wait_done(lat);
      check("dbz_latency",   lat, 34);
      check("dbz_quotient",  bus.quotient, 32'hFFFF_FFFF);
      check("dbz_remainder", bus.remainder, 32'h1234);
      step();

      // Data taint, then a clean run clears it
      launch(32'd50, 32'd5, 1'b1, 1'b0, 1'b0);
      wait_done(lat);
      check("dtaint_latency",   lat, 34);
      check("dtaint_quotient",  bus.quotient, 32'd10);
      check("dtaint_remainder", bus.remainder, 32'd0);
      check("dtaint_q_t",       {31'b0, bus.quotient_t}, 32'd1);
      check("dtaint_r_t",       {31'b0, bus.remainder_t}, 32'd1);
      check("dtaint_done_t",    {31'b0, bus.quotientDone_t}, 32'd0);
      step();
      launch(32'd9, 32'd4, 1'b0, 1'b0, 1'b0);
      wait_done(lat);
      check("clean_quotient",  bus.quotient, 32'd2);
      check("clean_remainder", bus.remainder, 32'd1);
      check("clean_taints",    {30'b0, bus.quotient_t, bus.remainder_t}, 32'h0);
      step();

      // Start during ITER is ignored
      launch(32'd1000, 32'd3, 1'b0, 1'b0, 1'b0);
      repeat (10) step();
      bus.dividend = 32'd77;
      bus.divisor  = 32'd5;
      bus.start    = 1'b1;
      step();
      bus.start    = 1'b0;
      wait_done(lat);
      check("busy_latency",   lat + 11, 34);
      check("busy_quotient",  bus.quotient, 32'd333);
      check("busy_remainder", bus.remainder, 32'd1);
      count_pulses(40, pulses);
      check("busy_extra_pulses", pulses, 0);

      // Control taint
      launch(32'd20, 32'd6, 1'b0, 1'b0, 1'b1);
      wait_done(lat);
      check("ctaint_latency",  lat, 34);
      check("ctaint_quotient", bus.quotient, 32'd3);
      check("ctaint_remainder", bus.remainder, 32'd2);
      check("ctaint_done_t",   {31'b0, bus.quotientDone_t}, 32'd1);
      check("ctaint_data_t",   {30'b0, bus.quotient_t, bus.remainder_t}, 32'd3);
      step();
      check("ctaint_after_done_t", {31'b0, bus.quotientDone_t}, {31'b0, ~KILL});
      launch(32'd7, 32'd7, 1'b0, 1'b0, 1'b0);
      wait_done(lat);
      check("ctaint2_quotient", bus.quotient, 32'd1);
      check("ctaint2_remainder", bus.remainder, 32'd0);
      check("ctaint2_done_t",  {31'b0, bus.quotientDone_t}, {31'b0, ~KILL});
      check("ctaint2_q_t",     {31'b0, bus.quotient_t}, {31'b0, ~KILL});
      step();

      // Reset during iteration 10
      launch(32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
      repeat (10) step();
      #2 rst = 1'b0;
      #1;
      check("midrst_quotient",  bus.quotient, 32'h0);
      check("midrst_remainder", bus.remainder, 32'h0);
      check("midrst_flags",     {28'b0, bus.quotientDone, bus.quotient_t, bus.remainder_t, bus.quotientDone_t}, 32'h0);
      step();
      rst = 1'b1;
      count_pulses(50, pulses);
      check("midrst_no_pulse", pulses, 0);

      // Recovery run after reset
      launch(32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
      wait_done(lat);
      check("post_latency",  lat, 34);
      check("post_quotient", bus.quotient, 32'd14);
      check("post_done_t",   {31'b0, bus.quotientDone_t}, 32'd0);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
